// File: rtl/axis_pkg.sv
// Shared types and constants for the jog axis controller: FSM state encoding
// and the direction level driven to the stepper driver.
package axis_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FWD    = 3'd1,
    REV    = 3'd2,
    HOMING = 3'd3,
    FAULT  = 3'd4
  } axis_state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // States in which the driver is enabled.
  function automatic logic state_moves(input axis_state_t s);
    return (s == FWD) || (s == REV) || (s == HOMING);
  endfunction

endpackage

// File: rtl/axis_jog_ctrl_if.sv
// Signal bundle between the axis controller and its surroundings (buttons,
// limit switches, step clock in; driver command and status out).
interface axis_jog_ctrl_if #(
  parameter int POS_W = 16
);
  // No valid/ready handshake here: every signal is a level, sampled on each
  // clk edge; raw inputs are asynchronous, en/direction are registered levels.
  logic                     step_clk;
  logic                     btn_fwd;
  logic                     btn_rev;
  logic                     lim_min;
  logic                     lim_max;
  logic                     en;
  logic                     direction;
  logic [POS_W-1:0]         position;
  logic                     homed;
  logic                     fault;
  axis_pkg::axis_state_t    state;

  modport master (
    output step_clk, btn_fwd, btn_rev, lim_min, lim_max,
    input  en, direction, position, homed, fault, state
  );

  modport slave (
    input  step_clk, btn_fwd, btn_rev, lim_min, lim_max,
    output en, direction, position, homed, fault, state
  );
endinterface

// File: rtl/jog_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output follows
// the synchronised input only after DEB_CYCLES consecutive cycles at a new level.
module jog_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             sync_in;

  assign sync_in = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

  // Any return to the current output level restarts the stability window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (sync_in == dout) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
      cnt  <= '0;
      dout <= sync_in;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/axis_jog_ctrl.sv
// Jog command stage for one claw axis: debounced buttons/limits in, en and
// direction out, with step position tracking. AXIS_JOG_AUTO_HOME_EN enables homing after reset.
module axis_jog_ctrl
  import axis_pkg::*;
#(
  parameter int DEB_CYCLES     = 1_000_000,
  parameter int POS_W          = 16,
  parameter int POS_MAX        = 4000,
  parameter int REV_GAP        = 2,
  parameter int HOME_MAX_STEPS = 8000
) (
  input  logic            clk,
  input  logic            rst,
  axis_jog_ctrl_if.slave  io
);

  localparam int               GAP_W   = $clog2(REV_GAP + 2);
  localparam int               HOME_W  = $clog2(HOME_MAX_STEPS + 1);
  localparam logic [POS_W-1:0] POS_LIM = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_TOP = '1;

`ifdef AXIS_JOG_AUTO_HOME_EN
  localparam axis_state_t RST_STATE = HOMING;
`else
  localparam axis_state_t RST_STATE = IDLE;
`endif

  logic             fwd_db, rev_db, min_db, max_db;
  logic             step_clk_q, tick;
  logic [GAP_W-1:0] gap_cnt;
  logic             gap_ok;
  logic [HOME_W-1:0] home_cnt;
  logic             home_timeout;
  logic [POS_W-1:0] position;
  logic             homed;
  logic             en, direction, fault;
  axis_state_t      state, state_nxt;

  jog_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_fwd (
    .clk(clk), .rst(rst), .din(io.btn_fwd), .dout(fwd_db));
  jog_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_rev (
    .clk(clk), .rst(rst), .din(io.btn_rev), .dout(rev_db));
  jog_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_min (
    .clk(clk), .rst(rst), .din(io.lim_min), .dout(min_db));
  jog_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db_max (
    .clk(clk), .rst(rst), .din(io.lim_max), .dout(max_db));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_clk_q <= 1'b0;
    end else begin
      step_clk_q <= io.step_clk;
    end
  end

  assign tick   = io.step_clk & ~step_clk_q;
  assign gap_ok = (gap_cnt == GAP_W'(REV_GAP));

  // Held at zero outside IDLE, so every entry to IDLE starts a fresh dead time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gap_cnt <= '0;
    end else if (state != IDLE) begin
      gap_cnt <= '0;
    end else if (tick && !gap_ok) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end

  assign home_timeout = tick && (home_cnt == HOME_W'(HOME_MAX_STEPS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      home_cnt <= '0;
    end else if (state != HOMING) begin
      home_cnt <= '0;
    end else if (tick) begin
      home_cnt <= home_cnt + HOME_W'(1);
    end
  end

  // The home switch wins over any step counted in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      position <= '0;
      homed    <= 1'b0;
    end else if (min_db) begin
      position <= '0;
      homed    <= 1'b1;
    end else if (tick && en) begin
      if (direction == DIR_FWD) begin
        if (position != POS_TOP) position <= position + POS_W'(1);
      end else begin
        if (position != '0) position <= position - POS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RST_STATE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gap_ok && fwd_db && !rev_db && !max_db && (position < POS_LIM)) begin
          state_nxt = FWD;
        end else if (gap_ok && rev_db && !fwd_db && !min_db) begin
          state_nxt = REV;
        end
      end
      FWD: begin
        if (!fwd_db || rev_db || max_db || (position >= POS_LIM)) state_nxt = IDLE;
      end
      REV: begin
        if (!rev_db || fwd_db || min_db) state_nxt = IDLE;
      end
      HOMING: begin
        if (min_db) begin
          state_nxt = IDLE;
        end else if (home_timeout) begin
          state_nxt = FAULT;
        end
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
    if (min_db && max_db) state_nxt = FAULT;
  end

  // Outputs are registered from the next state so en and direction change together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en        <= 1'b0;
      direction <= DIR_REV;
      fault     <= 1'b0;
    end else begin
      en    <= state_moves(state_nxt);
      fault <= (state_nxt == FAULT);
      if (state_nxt == FWD) begin
        direction <= DIR_FWD;
      end else if ((state_nxt == REV) || (state_nxt == HOMING)) begin
        direction <= DIR_REV;
      end
    end
  end

  assign io.en        = en;
  assign io.direction = direction;
  assign io.position  = position;
  assign io.homed     = homed;
  assign io.fault     = fault;
  assign io.state     = state;

endmodule
